// File: rtl/adder_bist.sv
// Built-in self-test for the adder path: sweeps every {cin, b, a} vector, checks sum/cout
// against a golden sum and reports error count, first failing vector and verdict.
// Optional ADDER_BIST_INJECT_EN adds an inject_err input that corrupts the golden sum.
module adder_bist #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned RESP_LAT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
`ifdef ADDER_BIST_INJECT_EN
   input  logic               inject_err,
`endif
   output logic [WIDTH-1:0]   dut_a,
   output logic [WIDTH-1:0]   dut_b,
   output logic               dut_cin,
   input  logic [WIDTH-1:0]   dut_sum,
   input  logic               dut_cout,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [15:0]        err_count,
   output logic [2*WIDTH:0]   first_fail_vec
);

   localparam int unsigned VEC_W  = 2*WIDTH + 1;
   localparam int unsigned SUM_W  = WIDTH + 1;
   localparam int unsigned WAIT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [VEC_W-1:0]  vec_q;
   logic [WAIT_W-1:0] wait_q;

   logic [SUM_W-1:0]  golden_c;
   logic [SUM_W-1:0]  resp_c;
   logic              mismatch_c;
   logic              check_c;
   logic              last_c;
   logic [15:0]       err_next_c;

   // Vector index is held in a flop and fanned straight out; it is zero outside RUN.
   assign dut_a   = vec_q[WIDTH-1:0];
   assign dut_b   = vec_q[2*WIDTH-1:WIDTH];
   assign dut_cin = vec_q[2*WIDTH];

   // Golden sum at full WIDTH+1 precision, optionally corrupted to self-test the checker.
   always_comb begin
      golden_c = SUM_W'(vec_q[WIDTH-1:0]) + SUM_W'(vec_q[2*WIDTH-1:WIDTH])
               + SUM_W'(vec_q[2*WIDTH]);
`ifdef ADDER_BIST_INJECT_EN
      golden_c[0] = golden_c[0] ^ inject_err;
`endif
   end

   assign resp_c     = {dut_cout, dut_sum};
   assign mismatch_c = (resp_c != golden_c);
   assign check_c    = (state == RUN) && (wait_q == WAIT_W'(RESP_LAT));
   assign last_c     = &vec_q;
   assign err_next_c = (mismatch_c && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

   // Sequencer: sweep vectors, register the check on the last cycle of each vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         vec_q          <= '0;
         wait_q         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= RUN;
                  vec_q          <= '0;
                  wait_q         <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  first_fail_vec <= '0;
               end
            end
            RUN: begin
               if (check_c) begin
                  err_count <= err_next_c;
                  if (mismatch_c && (err_count == 16'd0)) begin
                     first_fail_vec <= vec_q;
                  end
                  wait_q <= '0;
                  if (last_c) begin
                     state <= DONE;
                     vec_q <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next_c == 16'd0);
                  end else begin
                     vec_q <= vec_q + VEC_W'(1);
                  end
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: two instances (RESP_LAT 0 and 1) against a
// behavioural adder with selectable faults and a vector-enumerating result model.
module tb_adder_bist;

   localparam int NV = 512;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   int   mode = 0;
   bit   inj_on = 1'b0;

   logic [3:0] a0, b0, sum0, a1, b1, sum1;
   logic       cin0, cout0, busy0, done0, pass0;
   logic       cin1, cout1, busy1, done1, pass1;
   logic [15:0] err0, err1;
   logic [8:0]  ff0, ff1;
   logic        inject0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Adder under test for unit 0: 0 good, 1 sum[0] stuck 0, 2 cout stuck 1, 3 registered.
   logic [4:0] g0, resp0;
   logic [4:0] r0 = '0;
   assign g0 = 5'(a0) + 5'(b0) + 5'(cin0);
   always @(posedge clk) r0 <= g0;
   always_comb begin
      case (mode)
         0:       resp0 = g0;
         1:       resp0 = g0 & 5'b11110;
         2:       resp0 = g0 | 5'b10000;
         default: resp0 = r0;
      endcase
   end
   assign sum0  = resp0[3:0];
   assign cout0 = resp0[4];

   // Unit 1 always sees a good adder with one register stage.
   logic [4:0] r1 = '0;
   always @(posedge clk) r1 <= 5'(a1) + 5'(b1) + 5'(cin1);
   assign sum1  = r1[3:0];
   assign cout1 = r1[4];

   assign inject0 = inj_on && ({cin0, b0, a0} >= 9'd10) && ({cin0, b0, a0} <= 9'd12);

   adder_bist #(.WIDTH(4), .RESP_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
`ifdef ADDER_BIST_INJECT_EN
      .inject_err(inject0),
`endif
      .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(sum0), .dut_cout(cout0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail_vec(ff0)
   );

   adder_bist #(.WIDTH(4), .RESP_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef ADDER_BIST_INJECT_EN
      .inject_err(1'b0),
`endif
      .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_vec(ff1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // What a given adder model returns for vector v (with a RESP_LAT=0 checker).
   function automatic int adder_resp(input int md, input int v);
      int t;
      t = (v & 15) + ((v >> 4) & 15) + ((v >> 8) & 1);
      case (md)
         0: return t;
         1: return t & 30;
         2: return t | 16;
         default: begin
            if (v == 0) return 0;
            return ((v - 1) & 15) + (((v - 1) >> 4) & 15) + (((v - 1) >> 8) & 1);
         end
      endcase
   endfunction

   // Expected verdict of a full sweep: count mismatches against a + b + cin.
   task automatic exp_result(input int md, input bit inj, output int ec, output int ff);
      int g;
      ec = 0;
      ff = 0;
      for (int v = 0; v < NV; v++) begin
         g = (v & 15) + ((v >> 4) & 15) + ((v >> 8) & 1);
         if (inj && v >= 10 && v <= 12) g = g ^ 1;
         if (adder_resp(md, v) != g) begin
            if (ec == 0) ff = v;
            if (ec < 65535) ec++;
         end
      end
   endtask

   // Cycle-level model of unit 0's externally visible run.
   bit m_busy, m_done;
   int m_k, m_err, m_ff;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_k <= 0; m_err <= 0; m_ff <= 0;
      end else if (!m_busy) begin
         if (start0) begin
            m_busy <= 1'b1; m_done <= 1'b0; m_k <= 0; m_err <= 0; m_ff <= 0;
         end
      end else if (m_k == NV - 1) begin
         int ec, ff;
         exp_result(mode, inj_on, ec, ff);
         m_busy <= 1'b0; m_done <= 1'b1; m_k <= 0; m_err <= ec; m_ff <= ff;
      end else begin
         m_k <= m_k + 1;
      end
   end

   // Compare unit 0 against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", int'(busy0), int'(m_busy));
         chk("done", int'(done0), int'(m_done));
         chk("vector", int'({cin0, b0, a0}), m_busy ? m_k : 0);
         chk("pass", int'(pass0), int'(m_done && m_err == 0));
         if (m_done) begin
            chk("err_count", int'(err0), m_err);
            chk("first_fail_vec", int'(ff0), m_ff);
         end else if (!m_busy) begin
            chk("idle_err_count", int'(err0), 0);
            chk("idle_first_fail", int'(ff0), 0);
         end
      end
   end

   // Start a run, count busy cycles, poke start mid-run, optionally reset at a busy cycle.
   task automatic run_bist(input int unit, input int rst_at, output int cnt);
      bit b;
      @(negedge clk);
      if (unit == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (unit == 0) chk("err_cleared_on_start", int'(err0), 0);
      cnt = 0;
      for (int g = 0; g < 3000; g++) begin
         b = (unit == 0) ? busy0 : busy1;
         if (!b) break;
         cnt++;
         if (unit == 0) start0 = (cnt == 50); else start1 = (cnt == 50);
         if (cnt == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", int'(busy0), 0);
            chk("rst_done", int'(done0), 0);
            chk("rst_pass", int'(pass0), 0);
            chk("rst_err", int'(err0), 0);
            chk("rst_ff", int'(ff0), 0);
            chk("rst_vec", int'({cin0, b0, a0}), 0);
            chk("rst_busy1", int'(busy1), 0);
            @(negedge clk);
            #2 rst_n = 1'b1;
            break;
         end
         @(negedge clk);
      end
      start0 = 1'b0;
      start1 = 1'b0;
      b = (unit == 0) ? busy0 : busy1;
      if (b) chk("run_timeout", 1, 0);
   endtask

   initial begin
      int n;
      int ec, ff;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_pass", int'(pass0), 0);

      // Model pinned to hand-computed verdicts.
      exp_result(1, 1'b0, ec, ff);
      chk("model_sum0_err", ec, 256);
      exp_result(2, 1'b0, ec, ff);
      chk("model_cout1_ff", ff, 0);

      mode = 0;
      run_bist(0, -1, n);
      chk("good_busy_cycles", n, 512);
      chk("good_pass", int'(pass0), 1);
      chk("good_err", int'(err0), 0);
      chk("good_ff", int'(ff0), 0);

      mode = 1;
      run_bist(0, -1, n);
      chk("sum0_err", int'(err0), 256);
      chk("sum0_ff", int'(ff0), 1);
      chk("sum0_pass", int'(pass0), 0);

      mode = 2;
      run_bist(0, -1, n);
      chk("cout1_err", int'(err0), 256);
      chk("cout1_ff", int'(ff0), 0);
      chk("cout1_pass", int'(pass0), 0);

      mode = 3;
      run_bist(0, -1, n);
      chk("reg_lat0_pass", int'(pass0), 0);
      chk("reg_lat0_err_nonzero", int'(err0 != 16'd0), 1);

      run_bist(1, -1, n);
      chk("reg_lat1_busy_cycles", n, 1024);
      chk("reg_lat1_pass", int'(pass1), 1);
      chk("reg_lat1_err", int'(err1), 0);
      chk("reg_lat1_done", int'(done1), 1);

      mode = 0;
      run_bist(0, 100, n);
      chk("reset_at_cycle", n, 100);
      repeat (2) @(negedge clk);
      run_bist(0, -1, n);
      chk("after_reset_busy_cycles", n, 512);
      chk("after_reset_pass", int'(pass0), 1);

`ifdef ADDER_BIST_INJECT_EN
      inj_on = 1'b1;
      run_bist(0, -1, n);
      chk("inject_err_count", int'(err0), 3);
      chk("inject_ff", int'(ff0), 10);
      chk("inject_pass", int'(pass0), 0);
      @(negedge clk);
      inj_on = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
